// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS controller: state encodings,
// opcode/funct fields, ALU operation codes and datapath mux selects.
package mc_pkg;

  // FSM state encodings
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_IEXEC  = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // ALU operation codes
  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_ADDU = 8'h02;
  localparam logic [7:0] ALU_SUB  = 8'h03;
  localparam logic [7:0] ALU_SUBU = 8'h04;
  localparam logic [7:0] ALU_AND  = 8'h05;
  localparam logic [7:0] ALU_OR   = 8'h06;
  localparam logic [7:0] ALU_XOR  = 8'h07;
  localparam logic [7:0] ALU_NOR  = 8'h08;
  localparam logic [7:0] ALU_SLT  = 8'h09;
  localparam logic [7:0] ALU_SLTU = 8'h0A;
  localparam logic [7:0] ALU_LUI  = 8'h0B;
  localparam logic [7:0] ALU_SLL  = 8'h0C;
  localparam logic [7:0] ALU_SRL  = 8'h0D;
  localparam logic [7:0] ALU_SRA  = 8'h0E;

  // alusrcb selects
  localparam logic [1:0] ASRCB_B    = 2'b00;
  localparam logic [1:0] ASRCB_4    = 2'b01;
  localparam logic [1:0] ASRCB_IMM  = 2'b10;
  localparam logic [1:0] ASRCB_IMM4 = 2'b11;

  // pcsrc selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // Dispatch target out of DECODE; S_FETCH marks an unsupported encoding.
  function automatic logic [3:0] decode_target(input logic [5:0] op,
                                               input logic [5:0] funct,
                                               input logic [4:0] rt);
    logic [3:0] nxt;
    nxt = S_FETCH;
    case (op)
      OP_RTYPE: begin
        if (funct == F_JR) nxt = S_JR;
        else               nxt = S_EXEC;
      end
      OP_LW, OP_SW:   nxt = S_MEMADR;
      OP_BEQ, OP_BNE: nxt = S_BRANCH;
      OP_REGIMM: begin
        if ((rt == RT_BLTZ) || (rt == RT_BGEZ)) nxt = S_BRANCH;
        else                                    nxt = S_FETCH;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: nxt = S_IEXEC;
      OP_J:    nxt = S_JUMP;
      default: nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // Branch condition for the four supported conditional branches.
  function automatic logic branch_taken(input logic [5:0] op,
                                        input logic [4:0] rt,
                                        input logic       zero,
                                        input logic       srca_neg);
    logic tk;
    tk = 1'b0;
    case (op)
      OP_BEQ: tk = zero;
      OP_BNE: tk = ~zero;
      OP_REGIMM: begin
        if (rt == RT_BGEZ) tk = ~srca_neg;
        else               tk = srca_neg;
      end
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller (master) and the
// instruction register / datapath / memory side (slave).
interface mc_controller_if #(
  parameter int ALUC_W = 8,
  parameter int ST_W   = 4
);
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        rt;
  logic              zero;
  logic              srca_neg;
  logic              mem_ready;
  logic              mem_req;
  logic              memwrite;
  logic              iord;
  logic              irwrite;
  logic              pcwrite;
  logic              regwrite;
  logic              regdst;
  logic              memtoreg;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic              zeroext;
  logic [1:0]        pcsrc;
  logic [ALUC_W-1:0] alucontrol;
  logic              instr_done;
  logic              illegal;
  logic [ST_W-1:0]   state;

  modport master (
    input  op, funct, rt, zero, srca_neg, mem_ready,
    output mem_req, memwrite, iord, irwrite, pcwrite, regwrite, regdst,
           memtoreg, alusrca, alusrcb, zeroext, pcsrc, alucontrol,
           instr_done, illegal, state
  );

  modport slave (
    output op, funct, rt, zero, srca_neg, mem_ready,
    input  mem_req, memwrite, iord, irwrite, pcwrite, regwrite, regdst,
           memtoreg, alusrca, alusrcb, zeroext, pcsrc, alucontrol,
           instr_done, illegal, state
  );
endinterface

// File: rtl/mc_alu_sel.sv
// ALU operation select: fixed ADDU/SUBU for the address and branch steps,
// funct-driven in EXEC, opcode-driven in IEXEC, NOP everywhere else.
module mc_alu_sel
  import mc_pkg::*;
#(
  parameter int ALUC_W = 8,
  parameter int ST_W   = 4
) (
  input  logic [ST_W-1:0]   state_i,
  input  logic [5:0]        op_i,
  input  logic [5:0]        funct_i,
  output logic [ALUC_W-1:0] alucontrol_o
);

  // Map current state and instruction fields to an ALU operation
  always_comb begin
    alucontrol_o = ALU_NOP;
    case (state_i)
      S_FETCH, S_DECODE, S_MEMADR: alucontrol_o = ALU_ADDU;
      S_BRANCH:                    alucontrol_o = ALU_SUBU;
      S_EXEC: begin
        case (funct_i)
          F_ADD:   alucontrol_o = ALU_ADD;
          F_ADDU:  alucontrol_o = ALU_ADDU;
          F_SUB:   alucontrol_o = ALU_SUB;
          F_SUBU:  alucontrol_o = ALU_SUBU;
          F_AND:   alucontrol_o = ALU_AND;
          F_OR:    alucontrol_o = ALU_OR;
          F_XOR:   alucontrol_o = ALU_XOR;
          F_NOR:   alucontrol_o = ALU_NOR;
          F_SLT:   alucontrol_o = ALU_SLT;
          F_SLTU:  alucontrol_o = ALU_SLTU;
          F_SLL:   alucontrol_o = ALU_SLL;
          F_SRL:   alucontrol_o = ALU_SRL;
          F_SRA:   alucontrol_o = ALU_SRA;
          default: alucontrol_o = ALU_NOP;
        endcase
      end
      S_IEXEC: begin
        case (op_i)
          OP_ADDI:  alucontrol_o = ALU_ADD;
          OP_ADDIU: alucontrol_o = ALU_ADDU;
          OP_SLTI:  alucontrol_o = ALU_SLT;
          OP_ANDI:  alucontrol_o = ALU_AND;
          OP_ORI:   alucontrol_o = ALU_OR;
          OP_LUI:   alucontrol_o = ALU_LUI;
          default:  alucontrol_o = ALU_NOP;
        endcase
      end
      default: alucontrol_o = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS sequencer: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback. Outputs decode from the state
// register (pcwrite/irwrite/instr_done additionally qualified by mem_ready
// or the branch condition), so the async reset forces every output low
// immediately and no write can follow a reset.
module mc_controller
  import mc_pkg::*;
#(
  parameter int ALUC_W = 8,
  parameter int ST_W   = 4
) (
  input logic          clk,
  input logic          resetn,
  mc_controller_if.master bus
);

  logic [ST_W-1:0]   state_q;
  logic [ST_W-1:0]   state_d;
  logic [ST_W-1:0]   dispatch_s;
  logic              taken_s;
  logic [ALUC_W-1:0] aluc_s;

  logic       mem_req_s, memwrite_s, iord_s, irwrite_s, pcwrite_s;
  logic       regwrite_s, regdst_s, memtoreg_s, alusrca_s, zeroext_s;
  logic       instr_done_s, illegal_s;
  logic [1:0] alusrcb_s, pcsrc_s;

  assign dispatch_s = decode_target(bus.op, bus.funct, bus.rt);
  assign taken_s    = branch_taken(bus.op, bus.rt, bus.zero, bus.srca_neg);

  mc_alu_sel #(
    .ALUC_W (ALUC_W),
    .ST_W   (ST_W)
  ) u_alu_sel (
    .state_i      (state_q),
    .op_i         (bus.op),
    .funct_i      (bus.funct),
    .alucontrol_o (aluc_s)
  );

  // State register with asynchronous abort to IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state selection; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               state_d = S_FETCH;
      end
      S_DECODE: state_d = dispatch_s;
      S_MEMADR: begin
        if (bus.op == OP_SW) state_d = S_MEMWR;
        else                 state_d = S_MEMRD;
      end
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
        else               state_d = S_MEMRD;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready) state_d = S_FETCH;
        else               state_d = S_MEMWR;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_JR:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; IDLE and unused encodings drive all zeros
  always_comb begin
    mem_req_s    = 1'b0;
    memwrite_s   = 1'b0;
    iord_s       = 1'b0;
    irwrite_s    = 1'b0;
    pcwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = ASRCB_B;
    zeroext_s    = 1'b0;
    pcsrc_s      = PCSRC_ALU;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        alusrcb_s = ASRCB_4;
        pcsrc_s   = PCSRC_ALU;
        irwrite_s = bus.mem_ready;
        pcwrite_s = bus.mem_ready;
      end
      S_DECODE: begin
        alusrcb_s = ASRCB_IMM4;
        illegal_s = (dispatch_s == S_FETCH);
      end
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = ASRCB_IMM;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s   = 1'b1;
        memtoreg_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      S_MEMWR: begin
        mem_req_s    = 1'b1;
        memwrite_s   = 1'b1;
        iord_s       = 1'b1;
        instr_done_s = bus.mem_ready;
      end
      S_EXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = ASRCB_B;
      end
      S_ALUWB: begin
        regwrite_s   = 1'b1;
        regdst_s     = 1'b1;
        instr_done_s = 1'b1;
      end
      S_IEXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = ASRCB_IMM;
        zeroext_s = (bus.op == OP_ANDI) || (bus.op == OP_ORI);
      end
      S_IWB: begin
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = ASRCB_B;
        pcsrc_s      = PCSRC_ALUOUT;
        pcwrite_s    = taken_s;
        instr_done_s = 1'b1;
      end
      S_JUMP: begin
        pcsrc_s      = PCSRC_JUMP;
        pcwrite_s    = 1'b1;
        instr_done_s = 1'b1;
      end
      S_JR: begin
        pcsrc_s      = PCSRC_REGA;
        pcwrite_s    = 1'b1;
        instr_done_s = 1'b1;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  assign bus.mem_req    = mem_req_s;
  assign bus.memwrite   = memwrite_s;
  assign bus.iord       = iord_s;
  assign bus.irwrite    = irwrite_s;
  assign bus.pcwrite    = pcwrite_s;
  assign bus.regwrite   = regwrite_s;
  assign bus.regdst     = regdst_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.zeroext    = zeroext_s;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.alucontrol = aluc_s;
  assign bus.instr_done = instr_done_s;
  assign bus.illegal    = illegal_s;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed vector table, random
// instruction stream against an instruction-level reference model, and
// hand-written reset / mid-store abort sequences.
module tb_mc_controller;
  import mc_pkg::*;

  typedef struct {
    logic [5:0] op; logic [5:0] funct; logic [4:0] rt;
    bit zero; bit neg; int wf; int wm;
  } instr_t;

  typedef struct {
    int lat; int rw; int rwstall; int rdst; int m2r; int mreq; int mwr;
    int pcw; int fpcsrc; int irw; int done; int ill; int aluc; int zext;
  } res_t;

  typedef struct { instr_t i; int exp_lat; int exp_pcw; int exp_ill; } vec_t;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  mc_controller_if #(.ALUC_W(8), .ST_W(4)) bus ();

  mc_controller #(.ALUC_W(8), .ST_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before the test completed");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.pcwrite,
                 bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb,
                 bus.zeroext, bus.pcsrc, bus.alucontrol, bus.instr_done,
                 bus.illegal, bus.state});
  endfunction

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] funct,
                                input logic [4:0] rt, input bit zero, input bit neg,
                                input int wf, input int wm);
    instr_t i;
    i.op = op; i.funct = funct; i.rt = rt; i.zero = zero; i.neg = neg;
    i.wf = wf; i.wm = wm;
    return i;
  endfunction

  function automatic res_t blank();
    res_t e;
    e.lat = -1; e.rw = 0; e.rwstall = 0; e.rdst = -1; e.m2r = -1; e.mreq = 0;
    e.mwr = 0; e.pcw = 0; e.fpcsrc = 0; e.irw = 0; e.done = 0; e.ill = 0;
    e.aluc = -1; e.zext = 0;
    return e;
  endfunction

  function automatic int exp_alu_r(input logic [5:0] f);
    case (f)
      6'h20: return int'(ALU_ADD);  6'h21: return int'(ALU_ADDU);
      6'h22: return int'(ALU_SUB);  6'h23: return int'(ALU_SUBU);
      6'h24: return int'(ALU_AND);  6'h25: return int'(ALU_OR);
      6'h26: return int'(ALU_XOR);  6'h27: return int'(ALU_NOR);
      6'h2a: return int'(ALU_SLT);  6'h2b: return int'(ALU_SLTU);
      6'h00: return int'(ALU_SLL);  6'h02: return int'(ALU_SRL);
      6'h03: return int'(ALU_SRA);
      default: return -1;
    endcase
  endfunction

  function automatic int exp_alu_i(input logic [5:0] o);
    case (o)
      6'h08: return int'(ALU_ADD); 6'h09: return int'(ALU_ADDU);
      6'h0a: return int'(ALU_SLT); 6'h0c: return int'(ALU_AND);
      6'h0d: return int'(ALU_OR);  6'h0f: return int'(ALU_LUI);
      default: return -1;
    endcase
  endfunction

  // Instruction-level expectations: latency, write/request counts, final pcsrc.
  function automatic res_t model(input instr_t i);
    res_t e;
    bit   tk;
    e = blank();
    e.mreq = 1 + i.wf; e.pcw = 1; e.irw = 1; e.done = 1;
    if (i.op == 6'h00 && i.funct == 6'h08) begin
      e.lat = 3 + i.wf; e.pcw = 2; e.fpcsrc = 3;
    end else if (i.op == 6'h00) begin
      e.lat = 4 + i.wf; e.rw = 1; e.rdst = 1; e.m2r = 0; e.aluc = exp_alu_r(i.funct);
    end else if (i.op == 6'h23) begin
      e.lat = 5 + i.wf + i.wm; e.rw = 1; e.rdst = 0; e.m2r = 1;
      e.mreq = 2 + i.wf + i.wm; e.aluc = int'(ALU_ADDU);
    end else if (i.op == 6'h2b) begin
      e.lat = 4 + i.wf + i.wm; e.mreq = 2 + i.wf + i.wm; e.mwr = 1 + i.wm;
      e.aluc = int'(ALU_ADDU);
    end else if (i.op == 6'h04 || i.op == 6'h05 || (i.op == 6'h01 && i.rt <= 5'd1)) begin
      if (i.op == 6'h04)      tk = i.zero;
      else if (i.op == 6'h05) tk = !i.zero;
      else if (i.rt == 5'd0)  tk = i.neg;
      else                    tk = !i.neg;
      e.lat = 3 + i.wf; e.fpcsrc = 1; e.aluc = int'(ALU_SUBU);
      e.pcw = tk ? 2 : 1;
    end else if (i.op inside {6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f}) begin
      e.lat = 4 + i.wf; e.rw = 1; e.rdst = 0; e.m2r = 0; e.aluc = exp_alu_i(i.op);
      e.zext = (i.op == 6'h0c || i.op == 6'h0d) ? 1 : 0;
    end else if (i.op == 6'h02) begin
      e.lat = 3 + i.wf; e.pcw = 2; e.fpcsrc = 2;
    end else begin
      e.lat = 2 + i.wf; e.ill = 1; e.done = 0;
    end
    return e;
  endfunction

  // Runs one instruction from FETCH with a memory responder that inserts
  // wf wait cycles on the fetch and wm on the data access.
  task automatic run_instr(input instr_t ins, input bit sync, output res_t r);
    int wleft, post, n;
    bit fin;
    if (sync) begin @(posedge clk); #1; end
    bus.op = ins.op; bus.funct = ins.funct; bus.rt = ins.rt;
    bus.zero = ins.zero; bus.srca_neg = ins.neg;
    r = blank();
    wleft = ins.wf; post = -1; n = 0; fin = 1'b0;
    while (!fin && n < 60) begin
      @(negedge clk);
      if (bus.mem_req) bus.mem_ready = (wleft == 0);
      else             bus.mem_ready = 1'b0;
      #1;
      n++;
      if (post >= 0) post++;
      if (n == 1) check("start_state", int'(bus.state), int'(S_FETCH));
      if (bus.regwrite) begin
        r.rw++; r.rdst = int'(bus.regdst); r.m2r = int'(bus.memtoreg);
        if (bus.mem_req) r.rwstall++;
      end
      if (bus.mem_req) r.mreq++;
      if (bus.mem_req && bus.memwrite) r.mwr++;
      if (bus.pcwrite) r.pcw++;
      if (bus.irwrite) r.irw++;
      if (bus.instr_done) r.done++;
      if (bus.illegal) r.ill++;
      if (post == 2) begin r.aluc = int'(bus.alucontrol); r.zext = int'(bus.zeroext); end
      if (bus.instr_done || bus.illegal) begin
        fin = 1'b1; r.lat = n; r.fpcsrc = int'(bus.pcsrc);
      end
      if (bus.mem_req && !bus.mem_ready) wleft--;
      else if (bus.mem_req && bus.mem_ready) wleft = ins.wm;
      if (bus.irwrite) post = 0;
    end
  endtask

  task automatic cmp(input string tag, input res_t a, input res_t e);
    check({tag, ".latency"},  a.lat,     e.lat);
    check({tag, ".regwrite"}, a.rw,      e.rw);
    check({tag, ".rw_stall"}, a.rwstall, e.rwstall);
    check({tag, ".regdst"},   a.rdst,    e.rdst);
    check({tag, ".memtoreg"}, a.m2r,     e.m2r);
    check({tag, ".mem_req"},  a.mreq,    e.mreq);
    check({tag, ".memwrite"}, a.mwr,     e.mwr);
    check({tag, ".pcwrite"},  a.pcw,     e.pcw);
    check({tag, ".pcsrc"},    a.fpcsrc,  e.fpcsrc);
    check({tag, ".irwrite"},  a.irw,     e.irw);
    check({tag, ".done"},     a.done,    e.done);
    check({tag, ".illegal"},  a.ill,     e.ill);
    check({tag, ".zeroext"},  a.zext,    e.zext);
    if (e.aluc >= 0) check({tag, ".alucontrol"}, a.aluc, e.aluc);
  endtask

  vec_t vecs[15];
  logic [5:0] rops[16];
  logic [5:0] rfun[14];

  initial begin
    res_t r;
    instr_t ri;
    bit found;
    checks = 0; errors = 0;

    vecs[0]  = '{mk(6'h00, 6'h20, 5'd0, 1'b0, 1'b0, 0, 0), 4, 1, 0}; // add
    vecs[1]  = '{mk(6'h23, 6'h00, 5'd0, 1'b0, 1'b0, 0, 2), 7, 1, 0}; // lw, 2 waits
    vecs[2]  = '{mk(6'h04, 6'h00, 5'd0, 1'b0, 1'b0, 0, 0), 3, 1, 0}; // beq not taken
    vecs[3]  = '{mk(6'h04, 6'h00, 5'd0, 1'b1, 1'b0, 0, 0), 3, 2, 0}; // beq taken
    vecs[4]  = '{mk(6'h01, 6'h00, 5'd0, 1'b0, 1'b1, 0, 0), 3, 2, 0}; // bltz taken
    vecs[5]  = '{mk(6'h01, 6'h00, 5'd1, 1'b0, 1'b1, 0, 0), 3, 1, 0}; // bgez not taken
    vecs[6]  = '{mk(6'h05, 6'h00, 5'd0, 1'b0, 1'b0, 0, 0), 3, 2, 0}; // bne taken
    vecs[7]  = '{mk(6'h3f, 6'h00, 5'd0, 1'b0, 1'b0, 0, 0), 2, 1, 1}; // unsupported op
    vecs[8]  = '{mk(6'h2b, 6'h00, 5'd0, 1'b0, 1'b0, 1, 1), 6, 1, 0}; // sw, waits
    vecs[9]  = '{mk(6'h02, 6'h00, 5'd0, 1'b0, 1'b0, 0, 0), 3, 2, 0}; // j
    vecs[10] = '{mk(6'h00, 6'h08, 5'd0, 1'b0, 1'b0, 0, 0), 3, 2, 0}; // jr
    vecs[11] = '{mk(6'h0d, 6'h00, 5'd0, 1'b0, 1'b0, 2, 0), 6, 1, 0}; // ori, fetch waits
    vecs[12] = '{mk(6'h0f, 6'h00, 5'd0, 1'b0, 1'b0, 0, 0), 4, 1, 0}; // lui
    vecs[13] = '{mk(6'h01, 6'h00, 5'd2, 1'b0, 1'b0, 0, 0), 2, 1, 1}; // bad REGIMM rt
    vecs[14] = '{mk(6'h23, 6'h00, 5'd0, 1'b0, 1'b0, 0, 0), 5, 1, 0}; // lw zero-wait

    // Reset: everything low in IDLE, even with inputs active
    resetn = 1'b0;
    bus.op = 6'h23; bus.funct = 6'h20; bus.rt = 5'd0;
    bus.zero = 1'b1; bus.srca_neg = 1'b1; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    check("reset_state", int'(bus.state), int'(S_IDLE));
    resetn = 1'b1;
    #1;
    check("idle_after_release", outs(), 0);
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("first_fetch_state", int'(bus.state), int'(S_FETCH));
    check("first_fetch_mem_req", int'(bus.mem_req), 1);

    // Directed vector table
    for (int k = 0; k < 15; k++) begin
      run_instr(vecs[k].i, k != 0, r);
      check($sformatf("vec%0d.lat_table", k), r.lat, vecs[k].exp_lat);
      check($sformatf("vec%0d.pcw_table", k), r.pcw, vecs[k].exp_pcw);
      check($sformatf("vec%0d.ill_table", k), r.ill, vecs[k].exp_ill);
      cmp($sformatf("vec%0d", k), r, model(vecs[k].i));
    end

    // Random instruction stream against the model
    rops = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h01, 6'h08,
             6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h02, 6'h3f, 6'h0b};
    rfun = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
             6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08};
    for (int k = 0; k < 40; k++) begin
      ri = mk(rops[$urandom_range(15, 0)], rfun[$urandom_range(13, 0)],
              5'($urandom_range(2, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), int'($urandom_range(2, 0)),
              int'($urandom_range(3, 0)));
      run_instr(ri, 1'b1, r);
      cmp($sformatf("rnd%0d_op%0h", k, ri.op), r, model(ri));
    end

    // sw aborted by reset while MEMWR waits on memory
    @(posedge clk);
    #1;
    bus.op = 6'h2b; bus.funct = 6'h00; bus.rt = 5'd0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.state == S_MEMWR) found = 1'b1;
      else                      bus.mem_ready = bus.mem_req;
    end
    bus.mem_ready = 1'b0;
    #1;
    check("abort_reached_memwr", int'(found), 1);
    check("abort_pre_mem_req", int'(bus.mem_req), 1);
    check("abort_pre_memwrite", int'(bus.memwrite), 1);
    #2 resetn = 1'b0;
    #1;
    check("abort_mem_req", int'(bus.mem_req), 0);
    check("abort_memwrite", int'(bus.memwrite), 0);
    check("abort_state", int'(bus.state), int'(S_IDLE));
    check("abort_instr_done", int'(bus.instr_done), 0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("abort_held_outputs", outs(), 0);
    bus.mem_ready = 1'b0;
    resetn = 1'b1;
    #1;
    run_instr(vecs[0].i, 1'b1, r);
    cmp("post_abort_add", r, model(vecs[0].i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle sequencer for the MIPS datapath. It replaces single-cycle decode with a Moore FSM that steps one instruction through fetch, decode, execute, memory and writeback, using one shared ALU and one unified memory port.
- It drives all datapath enables and muxes, and holds in memory states until the memory reports ready.
- It sits between the instruction register (source of op/funct/rt) and the multicycle datapath/memory interface.

Parameters:
- ALUC_W, 8, width of alucontrol; values match the existing ALU encoding.
- ST_W, 4, width of the state register.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- rt  in  5  IR[20:16]; selects REGIMM variants.
- zero  in  1  ALU zero flag, same-cycle.
- srca_neg  in  1  sign bit of register A latch.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- memwrite  out  1  write qualifier for mem_req.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  latch instruction register.
- pcwrite  out  1  unconditional PC load.
- regwrite  out  1  register file write.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = memory data register, 0 = ALUOut.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- zeroext  out  1  immediate is zero-extended (andi/ori).
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A (jr).
- alucontrol  out  ALUC_W  ALU operation.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  one-cycle pulse for an unsupported encoding.
- state  out  ST_W  current state, for debug.

Behaviour:
- Moore FSM. All outputs decode from state, except pcwrite/irwrite/instr_done, which are qualified by mem_ready or the branch condition as noted below.
- Reset: while resetn = 0, state = IDLE and every output is 0. IDLE always moves to FETCH on the next edge.
- Reset asserted mid-instruction aborts immediately. No partial write may be issued after resetn falls.
- FETCH: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, alucontrol = ADDU, pcsrc = 00.
  - irwrite = pcwrite = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when it is 1.
- DECODE: alusrca = 0, alusrcb = 11, ADDU (precomputes branch target). Dispatch:
  - op 000000 with funct 001000 -> JR.
  - op 000000, any other funct -> EXEC.
  - 100011 / 101011 -> MEMADR.
  - 000100 / 000101 -> BRANCH.
  - 000001 with rt 00000 or 00001 -> BRANCH.
  - 001000 / 001001 / 001010 / 001100 / 001101 / 001111 -> IEXEC.
  - 000010 -> JUMP.
  - Anything else: illegal = 1, next state FETCH, no writes.
- MEMADR: alusrca = 1, alusrcb = 10, ADDU. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req = 1, iord = 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: regwrite = 1, regdst = 0, memtoreg = 1, instr_done = 1, then FETCH.
- MEMWR: mem_req = memwrite = 1, iord = 1. Wait for mem_ready; instr_done = mem_ready, then FETCH.
- EXEC: alusrca = 1, alusrcb = 00, alucontrol from funct, then ALUWB.
- ALUWB: regwrite = 1, regdst = 1, memtoreg = 0, instr_done = 1, then FETCH.
- IEXEC: alusrca = 1, alusrcb = 10, zeroext for andi/ori, alucontrol from op, then IWB.
- IWB: regwrite = 1, regdst = 0, memtoreg = 0, instr_done = 1, then FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, SUBU, pcsrc = 01, instr_done = 1, then FETCH. pcwrite is 1 when the condition holds:
  - beq: zero.
  - bne: !zero.
  - bltz: srca_neg.
  - bgez: !srca_neg.
- JUMP: pcsrc = 10, pcwrite = 1, instr_done = 1, then FETCH.
- JR: pcsrc = 11, pcwrite = 1, instr_done = 1, then FETCH.
- Latency with zero-wait memory:
  - R-type and I-ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch, j, jr: 3 cycles.
  - Each memory wait cycle adds exactly 1.
- Unused state encodings recover to FETCH with all outputs 0.

Decomposition:
- Package mc_pkg holds:
  - State encodings: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP, JR.
  - Opcode and funct constants.
  - ALU op constants, including ADDU and SUBU.
  - alusrcb and pcsrc select codes.
- Sub-module mc_alu_sel: combinational mapping from (state, op, funct) to alucontrol.

Test Plan:
- Reset: hold resetn = 0 for 3 cycles -> all outputs 0 and state = IDLE; after release, IDLE then FETCH with mem_req = 1.
- add (op 0, funct 100000), mem_ready tied 1 -> states FETCH, DECODE, EXEC, ALUWB; regwrite = regdst = 1 in cycle 4; instr_done in cycle 4 only.
- lw with mem_ready low for 2 cycles in MEMRD -> 7 cycles total; regwrite + memtoreg only in MEMWB; no regwrite while stalled.
- beq with zero = 0, then with zero = 1 -> pcwrite 0, then 1, in BRANCH with pcsrc = 01. bltz (op 1, rt 0) with srca_neg = 1 -> pcwrite = 1.
- Unsupported op 111111 -> illegal pulses in DECODE, next state FETCH, no regwrite or memwrite.
- sw, then resetn dropped in MEMWR before mem_ready -> mem_req and memwrite fall asynchronously, state = IDLE, and no instr_done pulse.
